// File: rtl/doorlock_entry_ctrl.sv
// doorlock_entry_ctrl: keypad code sequencer with timed unlock and failed-attempt lockout.
// Optional ENTRY_TIMEOUT_EN macro abandons a partial entry after TIMEOUT_CYC idle cycles.
module doorlock_entry_ctrl #(
    parameter int          CODE_LEN    = 4,
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int          MAX_FAIL    = 3,
    parameter int          UNLOCK_CYC  = 5000,
    parameter int          LOCKOUT_CYC = 20000,
    parameter int          TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    output logic       ps_start,
    output logic       ps_end,
    output logic       unlock,
    output logic       alarm,
    output logic       err,
    output logic [3:0] fail_cnt,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCK, LOCKOUT} state_t;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [15:0] MASK       = 16'hFFFF << (4 * (4 - CODE_LEN));
    localparam logic [15:0] UNLOCK_TC  = 16'(UNLOCK_CYC - 1);
    localparam logic [15:0] LOCKOUT_TC = 16'(LOCKOUT_CYC - 1);
    localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  LAST_IDX   = 3'(CODE_LEN - 1);
    localparam logic [3:0]  FAIL_MAX   = 4'(MAX_FAIL);
    state_t      state;
    logic [15:0] code_buf;
    logic [15:0] timer;
    logic [2:0]  idx;
    logic        is_digit;
    logic        is_clr;
    logic        match;
    logic        lock_now;
    logic [3:0]  fail_nxt;
    always_comb begin
        is_digit = key_valid && key_data <= 4'd9;
        is_clr   = key_valid && key_data == 4'hA;
        match    = (code_buf & MASK) == (PASSWORD & MASK);
        fail_nxt = fail_cnt == FAIL_MAX ? fail_cnt : fail_cnt + 4'd1;
        lock_now = fail_nxt == FAIL_MAX;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            code_buf <= '0;
            timer    <= '0;
            idx      <= '0;
            ps_start <= 1'b0;
            ps_end   <= 1'b0;
            unlock   <= 1'b0;
            alarm    <= 1'b0;
            err      <= 1'b0;
            fail_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            ps_start <= 1'b0;
            ps_end   <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: if (is_digit) begin
                    code_buf <= {key_data, 12'h000};
                    idx      <= 3'd1;
                    timer    <= '0;
                    ps_start <= 1'b1;
                    busy     <= 1'b1;
                    state    <= CODE_LEN == 1 ? CHECK : ENTRY;
                end
                ENTRY: if (is_clr) begin
                    code_buf <= '0;
                    idx      <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end else if (is_digit) begin
                    code_buf <= code_buf | ({key_data, 12'h000} >> {idx, 2'b00});
                    idx      <= idx + 3'd1;
                    timer    <= '0;
                    if (idx == LAST_IDX) state <= CHECK;
                end else if (TO_EN) begin
                    if (timer == TIMEOUT_TC) begin
                        code_buf <= '0;
                        idx      <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                CHECK: begin
                    code_buf <= '0;
                    idx      <= '0;
                    timer    <= '0;
                    if (match) begin
                        ps_end   <= 1'b1;
                        unlock   <= 1'b1;
                        fail_cnt <= '0;
                        state    <= UNLOCK;
                    end else begin
                        err      <= 1'b1;
                        fail_cnt <= fail_nxt;
                        alarm    <= lock_now;
                        busy     <= lock_now;
                        state    <= lock_now ? LOCKOUT : IDLE;
                    end
                end
                UNLOCK: if (timer == UNLOCK_TC) begin
                    unlock <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end else begin
                    timer <= timer + 16'd1;
                end
                LOCKOUT: if (timer == LOCKOUT_TC) begin
                    alarm    <= 1'b0;
                    fail_cnt <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end else begin
                    timer <= timer + 16'd1;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_doorlock_entry_ctrl.sv
// tb_doorlock_entry_ctrl: vector table plus directed sequences for lockout, clear, reset and timeout.
module tb_doorlock_entry_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_data = 4'h0;
    logic       ps_start, ps_end, unlock, alarm, err, busy;
    logic [3:0] fail_cnt;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       kv;
        logic [3:0] kd;
        int         n;
        logic [9:0] o;
    } vec_t;
    vec_t tv[15];

    doorlock_entry_ctrl #(
        .UNLOCK_CYC(8), .LOCKOUT_CYC(16), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
        .ps_start(ps_start), .ps_end(ps_end), .unlock(unlock), .alarm(alarm),
        .err(err), .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {ps_start, ps_end, unlock, alarm, err, busy, fail_cnt};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kd);
        @(negedge clk);
        key_valid = kv;
        key_data  = kd;
        @(posedge clk);
        #1;
    endtask

    task automatic code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        step(1, a); step(1, b); step(1, c); step(1, d); step(0, 0);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin
            step(0, 0);
            k++;
        end
        chk(name, 16'(busy), 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int hi;
        int starts;
        int errs;
        tv[0]  = '{1'b1, 4'h1, 1, 10'b100001_0000};
        tv[1]  = '{1'b1, 4'h2, 1, 10'b000001_0000};
        tv[2]  = '{1'b1, 4'h3, 1, 10'b000001_0000};
        tv[3]  = '{1'b1, 4'h4, 1, 10'b000001_0000};
        tv[4]  = '{1'b0, 4'h0, 1, 10'b011001_0000};
        tv[5]  = '{1'b1, 4'h9, 1, 10'b001001_0000};
        tv[6]  = '{1'b0, 4'h0, 6, 10'b001001_0000};
        tv[7]  = '{1'b0, 4'h0, 1, 10'b000000_0000};
        tv[8]  = '{1'b1, 4'h1, 1, 10'b100001_0000};
        tv[9]  = '{1'b1, 4'h2, 1, 10'b000001_0000};
        tv[10] = '{1'b1, 4'h3, 1, 10'b000001_0000};
        tv[11] = '{1'b1, 4'h5, 1, 10'b000001_0000};
        tv[12] = '{1'b0, 4'h0, 1, 10'b000010_0001};
        tv[13] = '{1'b0, 4'h0, 1, 10'b000000_0001};
        tv[14] = '{1'b1, 4'hB, 1, 10'b000000_0001};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 16'(outs()), 16'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++)
            for (int r = 0; r < tv[i].n; r++) begin
                step(tv[i].kv, tv[i].kd);
                chk($sformatf("vec%0d_rep%0d", i, r), 16'(outs()), 16'(tv[i].o));
            end

        // three wrong codes reach lockout; keys during lockout must do nothing
        do_reset();
        code(1, 2, 3, 5);
        code(1, 2, 3, 6);
        code(1, 2, 3, 7);
        chk("lockout_alarm", 16'(alarm), 16'd1);
        chk("lockout_fail_cnt", 16'(fail_cnt), 16'd3);
        chk("lockout_err", 16'(err), 16'd1);
        hi = 1;
        starts = 0;
        for (int k = 0; k < 40 && alarm; k++) begin
            step(1, 4'(k % 5));
            starts += int'(ps_start);
            hi += int'(alarm);
        end
        chk("lockout_len", 16'(hi), 16'd16);
        chk("lockout_keys_ignored", 16'(starts), 16'd0);
        chk("lockout_exit_fail_cnt", 16'(fail_cnt), 16'd0);
        chk("lockout_exit_busy", 16'(busy), 16'd0);
        code(1, 2, 3, 4);
        chk("post_lockout_unlock", 16'(unlock), 16'd1);
        chk("post_lockout_ps_end", 16'(ps_end), 16'd1);
        wait_idle("unlock_timeout");

        // clear mid-entry then a correct code
        starts = 0;
        errs = 0;
        step(1, 1); starts += int'(ps_start);
        step(1, 2); starts += int'(ps_start);
        step(1, 4'hA); starts += int'(ps_start); errs += int'(err);
        chk("clear_to_idle", 16'(busy), 16'd0);
        step(1, 1); starts += int'(ps_start);
        step(1, 2); starts += int'(ps_start);
        step(1, 3); starts += int'(ps_start);
        step(1, 4); starts += int'(ps_start); errs += int'(err);
        step(0, 0); errs += int'(err);
        chk("clear_then_unlock", 16'(unlock), 16'd1);
        chk("clear_ps_start_count", 16'(starts), 16'd2);
        chk("clear_no_err", 16'(errs), 16'd0);
        wait_idle("unlock_timeout2");

        // asynchronous reset mid-entry, then non-digits in IDLE
        step(1, 1);
        step(1, 2);
        @(negedge clk);
        key_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 16'(outs()), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 4'hB);
        chk("ignore_B", 16'({ps_start, busy}), 16'd0);
        step(1, 4'hF);
        chk("ignore_F", 16'({ps_start, busy}), 16'd0);
        step(0, 0);

        step(1, 1);
`ifdef ENTRY_TIMEOUT_EN
        errs = 0;
        for (int k = 0; k < 9; k++) begin
            step(0, 0);
            errs += int'(err);
        end
        chk("timeout_busy_before", 16'(busy), 16'd1);
        step(0, 0);
        errs += int'(err);
        chk("timeout_to_idle", 16'(busy), 16'd0);
        chk("timeout_no_err", 16'(errs), 16'd0);
        chk("timeout_fail_cnt", 16'(fail_cnt), 16'd0);
`else
        repeat (1000) step(0, 0);
        chk("no_timeout_busy", 16'(busy), 16'd1);
        step(1, 4'hA);
        chk("no_timeout_clear", 16'(busy), 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
